// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for an iterative AES inverse cipher: validates Nk/Nr, triggers
// key expansion when needed, walks the round index from Nr down to 0, then holds the result.
module aes_dec_round_ctrl #(
  parameter int RW          = 4,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          new_key,
  input  logic [RW-1:0] nk,
  input  logic [RW-1:0] nr,
  input  logic          abort,
  output logic          ready,
  output logic          busy,
  output logic          key_start,
  input  logic          key_done,
  input  logic          key_err,
  output logic [RW-1:0] round,
  output logic          st_ld,
  output logic          sel_init,
  output logic          sel_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int CW = $clog2(KEY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_KEY, S_INIT, S_ROUND, S_FINAL, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [RW-1:0] nr_q, nr_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          key_valid_q, key_valid_d;
  logic          pair_ok;

  assign pair_ok = (nk == RW'(4) && nr == RW'(10)) ||
                   (nk == RW'(6) && nr == RW'(12)) ||
                   (nk == RW'(8) && nr == RW'(14));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      nr_q        <= '0;
      tmo_q       <= '0;
      err_code_q  <= 2'b00;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      nr_q        <= nr_d;
      tmo_q       <= tmo_d;
      err_code_q  <= err_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // NOTE: every output and _d signal gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    nr_d        = nr_q;
    tmo_d       = tmo_q;
    err_code_d  = err_code_q;
    key_valid_d = key_valid_q;
    key_start   = 1'b0;
    st_ld       = 1'b0;
    sel_init    = 1'b0;
    sel_last    = 1'b0;
    out_valid   = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_code_d = 2'b00;
          nr_d       = nr;
          if (!pair_ok) begin
            err_code_d = 2'b01;
            state_d    = S_ERR;
          end else if (new_key || !key_valid_q) begin
            key_start   = 1'b1;
            key_valid_d = 1'b0;
            tmo_d       = '0;
            state_d     = S_WAIT_KEY;
          end else begin
            round_d = nr;
            state_d = S_INIT;
          end
        end
      end
      S_WAIT_KEY: begin
        tmo_d = tmo_q + 1'b1;
        if (key_err) begin
          err_code_d  = 2'b10;
          key_valid_d = 1'b0;
          state_d     = S_ERR;
        end else if (key_done) begin
          key_valid_d = 1'b1;
          round_d     = nr_q;
          state_d     = S_INIT;
        end else if (tmo_q == CW'(KEY_TIMEOUT - 1)) begin
          err_code_d  = 2'b11;
          key_valid_d = 1'b0;
          state_d     = S_ERR;
        end
      end
      S_INIT: begin
        st_ld    = 1'b1;
        sel_init = 1'b1;
        round_d  = round_q - 1'b1;
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        st_ld   = 1'b1;
        round_d = round_q - 1'b1;
        if (round_q == RW'(1)) state_d = S_FINAL;
      end
      S_FINAL: begin
        st_ld    = 1'b1;
        sel_last = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever transition the state decided on this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      round_d    = '0;
      err_code_d = err_code_q;
      if (state_q == S_WAIT_KEY) key_valid_d = 1'b0;
      else                       key_valid_d = key_valid_q;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = ~ready;
  assign round    = round_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl: a queue holds the expected round index and
// selects for every st_ld pulse; a negedge monitor pops and compares them.
module tb_aes_dec_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, new_key, abort, key_done, key_err, out_ready;
  logic [3:0] nk, nr;
  logic       ready, busy, key_start, st_ld, sel_init, sel_last, out_valid, err;
  logic [3:0] round;
  logic [1:0] err_code;

  typedef struct packed {
    logic [3:0] rnd;
    logic       init;
    logic       last;
  } ld_t;

  ld_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  aes_dec_round_ctrl #(.RW(4), .KEY_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .new_key(new_key), .nk(nk), .nr(nr),
    .abort(abort), .ready(ready), .busy(busy), .key_start(key_start),
    .key_done(key_done), .key_err(key_err), .round(round), .st_ld(st_ld),
    .sel_init(sel_init), .sel_last(sel_last), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [3:0] r);
    for (int i = int'(r); i >= 0; i--) begin
      exp_q.push_back('{rnd: 4'(i), init: (i == int'(r)), last: (i == 0)});
    end
  endtask

  // Every st_ld pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (st_ld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected st_ld", 32'(round), 32'hFFFF);
      end else begin
        ld_t e;
        e = exp_q.pop_front();
        check("st_ld round/init/last", 32'({round, sel_init, sel_last}),
              32'({e.rnd, e.init, e.last}));
      end
    end
  end

  task automatic accept(input logic [3:0] k, input logic [3:0] r, input logic nkey,
                        input logic exp_ks, input string tag);
    nk = k; nr = r; new_key = nkey; start = 1'b1;
    #1;
    check({tag, " key_start"}, 32'(key_start), 32'(exp_ks));
    check({tag, " ready at accept"}, 32'(ready), 32'd1);
    cyc();
    start = 1'b0; new_key = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check({tag, " ready after handshake"}, 32'(ready), 32'd1);
    check({tag, " out_valid dropped"}, 32'(out_valid), 32'd0);
    check({tag, " all st_ld consumed"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic key_arrives();
    key_done = 1'b1;
    cyc();
    key_done = 1'b0;
    check("INIT after key_done", 32'(sel_init), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; new_key = 1'b0; abort = 1'b0; key_done = 1'b0;
    key_err = 1'b0; out_ready = 1'b0; nk = 4'd0; nr = 4'd0;
    cyc(); cyc();
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset round", 32'(round), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset strobes", 32'({st_ld, sel_init, sel_last, out_valid, err, key_start}), 32'd0);
    rst = 1'b0;
    cyc();

    // 1: AES-128 with re-key, key_done sampled 5 cycles after key_start
    push_op(4'd10);
    accept(4'd4, 4'd10, 1'b1, 1'b1, "c1");
    check("c1 busy in WAIT_KEY", 32'(busy), 32'd1);
    repeat (4) cyc();
    check("c1 no st_ld while waiting", 32'(st_ld), 32'd0);
    key_arrives();
    check("c1 INIT round", 32'(round), 32'd10);
    wait_valid(100, n);
    check("c1 out_valid latency after key_done", 32'(n + 1), 32'd12);
    check("c1 round at DONE", 32'(round), 32'd0);
    handshake("c1");

    // 2: same key reused, INIT immediately after accept
    push_op(4'd10);
    accept(4'd4, 4'd10, 1'b0, 1'b0, "c2");
    check("c2 INIT next cycle", 32'(sel_init), 32'd1);
    check("c2 INIT round", 32'(round), 32'd10);
    wait_valid(100, n);
    check("c2 out_valid latency after accept", 32'(n + 1), 32'd12);
    handshake("c2");

    // 3: illegal Nk/Nr pair
    accept(4'd6, 4'd14, 1'b1, 1'b0, "c3");
    check("c3 err pulse", 32'(err), 32'd1);
    check("c3 err_code", 32'(err_code), 32'd1);
    check("c3 not ready during ERR", 32'(ready), 32'd0);
    cyc();
    check("c3 err single cycle", 32'(err), 32'd0);
    check("c3 ready 2 cycles after accept", 32'(ready), 32'd1);
    check("c3 err_code held", 32'(err_code), 32'd1);

    // 4: key expansion never finishes -> timeout
    accept(4'd4, 4'd10, 1'b1, 1'b1, "c4");
    check("c4 err_code cleared on accept", 32'(err_code), 32'd0);
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check("c4 WAIT_KEY cycles before timeout", 32'(n), 32'd64);
    check("c4 err_code timeout", 32'(err_code), 32'd3);
    cyc();
    check("c4 ready after timeout", 32'(ready), 32'd1);
    push_op(4'd10);
    accept(4'd4, 4'd10, 1'b0, 1'b1, "c4 rekey after timeout");
    key_arrives();
    wait_valid(100, n);
    check("c4 latency after key_done", 32'(n + 1), 32'd12);
    handshake("c4");

    // key_err and key_done together: error wins
    accept(4'd6, 4'd12, 1'b1, 1'b1, "kerr");
    key_err = 1'b1; key_done = 1'b1;
    cyc();
    key_err = 1'b0; key_done = 1'b0;
    check("kerr err pulse", 32'(err), 32'd1);
    check("kerr err_code", 32'(err_code), 32'd2);
    check("kerr no INIT", 32'(st_ld), 32'd0);
    cyc();

    // 5: AES-256, consumer stalls 7 cycles while start is pulsed
    push_op(4'd14);
    accept(4'd8, 4'd14, 1'b0, 1'b1, "c5 rekey after key_err");
    key_arrives();
    wait_valid(100, n);
    check("c5 latency after key_done", 32'(n + 1), 32'd16);
    for (int i = 0; i < 7; i++) begin
      start = 1'b1; new_key = 1'b1; nk = 4'd4; nr = 4'd10;
      #1;
      check("c5 start ignored while busy", 32'(key_start), 32'd0);
      check("c5 out_valid held", 32'(out_valid), 32'd1);
      cyc();
    end
    start = 1'b0; new_key = 1'b0;
    check("c5 out_valid still held", 32'(out_valid), 32'd1);
    handshake("c5");
    cyc();
    check("c5 start not queued", 32'({ready, st_ld}), 32'b10);

    // 6a: abort mid-round keeps the key
    push_op(4'd10);
    accept(4'd4, 4'd10, 1'b0, 1'b0, "c6a");
    n = 0;
    while (round !== 4'd5 && n < 50) begin
      cyc();
      n++;
    end
    check("c6a reached round 5", 32'(round), 32'd5);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("c6a idle after abort", 32'(ready), 32'd1);
    check("c6a unconsumed loads", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    repeat (14) begin
      cyc();
      if (out_valid !== 1'b0 || err !== 1'b0) check("c6a no out_valid/err after abort", 32'({out_valid, err}), 32'd0);
    end
    check("c6a quiet after abort", 32'({out_valid, err, st_ld}), 32'd0);

    // 6b: reset mid-round forces a re-key
    push_op(4'd10);
    accept(4'd4, 4'd10, 1'b0, 1'b0, "c6b key kept after abort");
    n = 0;
    while (round !== 4'd3 && n < 50) begin
      cyc();
      n++;
    end
    check("c6b reached round 3", 32'(round), 32'd3);
    rst = 1'b1; abort = 1'b1;
    cyc();
    rst = 1'b0; abort = 1'b0;
    check("c6b idle after rst", 32'(ready), 32'd1);
    check("c6b round cleared", 32'(round), 32'd0);
    check("c6b unconsumed loads", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    push_op(4'd12);
    accept(4'd6, 4'd12, 1'b0, 1'b1, "c6b rekey after rst");
    key_arrives();
    wait_valid(100, n);
    check("c6b latency after key_done", 32'(n + 1), 32'd14);
    check("c6b out_valid", 32'(out_valid), 32'd1);
    handshake("c6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
